// File: rtl/cmem_loader_if.sv
// Stream and memory-port signals between the coefficient loader and its
// surroundings. The loader uses the slave view; the host/cmem side uses master.
interface cmem_loader_if #(
    parameter int AW = 8,
    parameter int DW = 20
);
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          CEN;
    logic          WEN;
    logic [AW-1:0] CADDR;
    logic [DW-1:0] D;
    logic [AW-1:0] A0;
    logic [DW-1:0] Q0;

    modport slave (
        input  in_valid, in_data, Q0,
        output in_ready, CEN, WEN, CADDR, D, A0
    );

    modport master (
        output in_valid, in_data, Q0,
        input  in_ready, CEN, WEN, CADDR, D, A0
    );
endinterface

// File: rtl/cmem_loader.sv
// Coefficient memory loader: writes a stream of words into consecutive cmem
// addresses (wrapping modulo depth), reads the region back and flags a
// checksum mismatch.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; outputs hold last result
// LOAD  | accepting words, one write cycle per accepted word
// DRAIN | final write cycle in flight
// READ  | issuing one readback address per cycle
// FLUSH | last readback address being sampled by cmem
// CHECK | last readback word arrives; compare sums, pulse done
module cmem_loader #(
    parameter int AW = 8,
    parameter int DW = 20,
    parameter int SW = 28
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [AW:0]   len,
    cmem_loader_if.slave  bus,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [SW-1:0] wsum
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LOAD  = 3'd1;
    localparam logic [2:0] DRAIN = 3'd2;
    localparam logic [2:0] READ  = 3'd3;
    localparam logic [2:0] FLUSH = 3'd4;
    localparam logic [2:0] CHECK = 3'd5;

    localparam logic [AW:0] DEPTH = (AW+1)'(1 << AW);
    localparam logic [AW:0] ONE   = (AW+1)'(1);

    logic [2:0]    state;
    logic [AW-1:0] base_r;
    logic [AW:0]   len_r;
    logic [AW:0]   cnt;
    logic [AW:0]   cnt_inc;
    logic [AW-1:0] addr;
    logic          wr_pending;
    logic          len_err;
    logic          a0_live;   // a read address is on A0 this cycle
    logic          q_live;    // Q0 carries data for last cycle's read address
    logic [SW-1:0] rsum;
    logic [SW-1:0] rsum_nxt;
    logic [SW-1:0] in_ext;
    logic [SW-1:0] q_ext;
    logic          hs;

    // Input is refused while a write cycle is in flight: max one word per two cycles.
    assign bus.in_ready = (state == LOAD) && !wr_pending;
    assign hs           = bus.in_valid && bus.in_ready;
    assign cnt_inc      = cnt + ONE;
    assign addr         = base_r + cnt[AW-1:0];
    assign in_ext       = {{(SW-DW){1'b0}}, bus.in_data};
    assign q_ext        = {{(SW-DW){1'b0}}, bus.Q0};
    // The final readback word arrives during CHECK, so the compare uses the
    // sum including the word currently on Q0.
    assign rsum_nxt     = q_live ? (rsum + q_ext) : rsum;

    // Sequencer, memory-port drive and checksum accumulation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            base_r     <= '0;
            len_r      <= '0;
            cnt        <= '0;
            wr_pending <= 1'b0;
            len_err    <= 1'b0;
            a0_live    <= 1'b0;
            q_live     <= 1'b0;
            rsum       <= '0;
            wsum       <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            bus.CEN    <= 1'b1;
            bus.WEN    <= 1'b1;
            bus.CADDR  <= '0;
            bus.D      <= '0;
            bus.A0     <= '0;
        end else begin
            done   <= 1'b0;
            q_live <= a0_live;
            rsum   <= rsum_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        base_r <= base_addr;
                        len_r  <= len;
                        wsum   <= '0;
                        rsum   <= '0;
                        cnt    <= '0;
                        err    <= 1'b0;
                        busy   <= 1'b1;
                        if (len > DEPTH) begin
                            len_err <= 1'b1;
                            state   <= CHECK;
                        end else if (len == '0) begin
                            len_err <= 1'b0;
                            state   <= CHECK;
                        end else begin
                            len_err <= 1'b0;
                            state   <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (wr_pending) begin
                        bus.CEN    <= 1'b1;
                        bus.WEN    <= 1'b1;
                        wr_pending <= 1'b0;
                    end
                    if (hs) begin
                        bus.CEN    <= 1'b0;
                        bus.WEN    <= 1'b0;
                        bus.CADDR  <= addr;
                        bus.D      <= bus.in_data;
                        wsum       <= wsum + in_ext;
                        cnt        <= cnt_inc;
                        wr_pending <= 1'b1;
                        if (cnt_inc == len_r) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    bus.CEN    <= 1'b1;
                    bus.WEN    <= 1'b1;
                    wr_pending <= 1'b0;
                    cnt        <= '0;
                    state      <= READ;
                end
                READ: begin
                    bus.CEN <= 1'b0;
                    bus.WEN <= 1'b1;
                    bus.A0  <= addr;
                    a0_live <= 1'b1;
                    cnt     <= cnt_inc;
                    if (cnt_inc == len_r) begin
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    bus.CEN <= 1'b1;
                    a0_live <= 1'b0;
                    state   <= CHECK;
                end
                CHECK: begin
                    err   <= len_err || (rsum_nxt != wsum);
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmem_loader.sv
// Bench for cmem_loader: cmem behavioural model, a queue-based expectation
// model built from each operation's word list, and directed operations.
module tb_cmem_loader;
    localparam int AW = 8;
    localparam int DW = 20;
    localparam int SW = 28;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   len;
    logic          busy;
    logic          done;
    logic          err;
    logic [SW-1:0] wsum;

    cmem_loader_if #(.AW(AW), .DW(DW)) bus ();

    cmem_loader #(.AW(AW), .DW(DW), .SW(SW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .wsum      (wsum)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  a;
        logic [19:0] d;
    } wr_t;

    int          checks = 0;
    int          failures = 0;
    wr_t         exp_w[$];
    logic [7:0]  exp_r[$];
    logic [7:0]  a0_log[$];
    wr_t         cur_w;
    logic [19:0] wbuf [256];
    logic [19:0] mem [256];
    logic [27:0] exp_sum;
    logic [27:0] run_sum;
    logic        exp_err;
    logic        model_on;
    logic [7:0]  last_a;
    logic [19:0] last_d;
    int          n_wr;
    int          n_rd;
    logic        corrupt_en;
    logic [7:0]  corrupt_addr;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // cmem: one write or one read per enabled cycle, read data one cycle later.
    always @(posedge clk) begin
        if (!bus.CEN && !bus.WEN) mem[bus.CADDR] <= bus.D;
        if (!bus.CEN && bus.WEN)
            bus.Q0 <= (corrupt_en && bus.A0 == corrupt_addr) ? (mem[bus.A0] ^ 20'd1) : mem[bus.A0];
    end

    // Compare process: every write/read cycle and every done pulse.
    always @(negedge clk) begin
        if (!rst && model_on) begin
            if (!bus.CEN && !bus.WEN) begin
                n_wr++;
                if (exp_w.size() == 0) begin
                    check("unexpected_write", 1, 0);
                end else begin
                    cur_w = exp_w.pop_front();
                    check("write_addr", bus.CADDR, cur_w.a);
                    check("write_data", bus.D, cur_w.d);
                    run_sum = run_sum + {8'd0, cur_w.d};
                    check("wsum_live", wsum, run_sum);
                    check("in_ready_masked", bus.in_ready, 0);
                    last_a = cur_w.a;
                    last_d = cur_w.d;
                end
            end
            if (!bus.CEN && bus.WEN) begin
                n_rd++;
                a0_log.push_back(bus.A0);
                if (exp_r.size() == 0) begin
                    check("unexpected_read", 1, 0);
                end else begin
                    check("read_addr", bus.A0, exp_r.pop_front());
                    check("caddr_held", bus.CADDR, last_a);
                    check("d_held", bus.D, last_d);
                end
            end
            if (done) begin
                check("done_err", err, exp_err);
                check("done_wsum", wsum, exp_sum);
                check("done_busy", busy, 0);
            end
        end
    end

    task automatic run_op(input logic [7:0] b, input logic [8:0] n,
                          input int stall_at, input int start_at, input logic corrupt);
        logic [27:0] rdsum;
        wr_t         e;
        int          waited;
        int          wr0;
        int          rd0;
        int          w0;
        exp_w.delete();
        exp_r.delete();
        a0_log.delete();
        run_sum = '0;
        exp_sum = '0;
        rdsum   = '0;
        corrupt_en   = corrupt;
        corrupt_addr = b + 8'd2;
        if (n <= 9'd256) begin
            for (int i = 0; i < int'(n); i++) begin
                e.a = b + 8'(i);
                e.d = wbuf[i];
                exp_w.push_back(e);
                exp_r.push_back(b + 8'(i));
                exp_sum = exp_sum + {8'd0, wbuf[i]};
                rdsum   = rdsum + {8'd0, ((corrupt && i == 2) ? (wbuf[i] ^ 20'd1) : wbuf[i])};
            end
        end
        exp_err = (n > 9'd256) || (rdsum != exp_sum);
        wr0 = n_wr;
        rd0 = n_rd;

        @(negedge clk);
        start = 1'b1;
        base_addr = b;
        len = n;
        @(negedge clk);
        start = 1'b0;

        if (n == 9'd0 || n > 9'd256) begin
            @(negedge clk);
            check("done_latency", done, 1);
            check("no_mem_write", n_wr - wr0, 0);
            check("no_mem_read", n_rd - rd0, 0);
        end else begin
            check("busy_after_start", busy, 1);
            for (int i = 0; i < int'(n); i++) begin
                if (i == stall_at) begin
                    bus.in_valid = 1'b0;
                    @(negedge clk);
                    w0 = n_wr;
                    repeat (9) @(negedge clk);
                    check("stall_no_write", n_wr - w0, 0);
                end
                bus.in_valid = 1'b1;
                bus.in_data  = wbuf[i];
                if (i == start_at) begin
                    start = 1'b1;
                    base_addr = 8'h80;
                    len = 9'd2;
                end
                waited = 0;
                while (!bus.in_ready && waited < 50) begin
                    @(negedge clk);
                    waited++;
                end
                if (!bus.in_ready) check("in_ready_timeout", 0, 1);
                @(negedge clk);
                start = 1'b0;
            end
            bus.in_valid = 1'b0;
            waited = 0;
            while (!done && waited < 2000) begin
                @(negedge clk);
                waited++;
            end
            check("done_seen", done, 1);
            check("write_count", n_wr - wr0, n);
            check("read_count", n_rd - rd0, n);
        end
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("err_hold", err, exp_err);
    endtask

    initial begin
        int waited;
        rst = 1'b0;
        start = 1'b0;
        base_addr = '0;
        len = '0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        model_on = 1'b0;
        corrupt_en = 1'b0;
        corrupt_addr = '0;
        n_wr = 0;
        n_rd = 0;
        run_sum = '0;
        exp_sum = '0;
        exp_err = 1'b0;
        last_a = '0;
        last_d = '0;

        #1 rst = 1'b1;
        #1;
        check("rst_cen", bus.CEN, 1);
        check("rst_wen", bus.WEN, 1);
        check("rst_caddr", bus.CADDR, 0);
        check("rst_d", bus.D, 0);
        check("rst_a0", bus.A0, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_wsum", wsum, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", bus.in_ready, 0);
        check("idle_cen", bus.CEN, 1);
        model_on = 1'b1;

        // Full memory, random data.
        for (int i = 0; i < 256; i++) wbuf[i] = 20'($urandom_range(0, 20'hFFFFF));
        run_op(8'h00, 9'd256, -1, -1, 1'b0);

        // Wrapping region with hand-known data.
        for (int i = 0; i < 4; i++) wbuf[i] = 20'(i + 1);
        run_op(8'hFE, 9'd4, -1, -1, 1'b0);
        check("wrap_wsum", wsum, 28'd10);
        check("wrap_err", err, 0);
        check("wrap_a0_count", a0_log.size(), 4);
        check("wrap_a0_0", a0_log[0], 8'hFE);
        check("wrap_a0_1", a0_log[1], 8'hFF);
        check("wrap_a0_2", a0_log[2], 8'h00);
        check("wrap_a0_3", a0_log[3], 8'h01);

        // Empty and oversize lengths.
        run_op(8'h10, 9'd0, -1, -1, 1'b0);
        check("len0_err", err, 0);
        run_op(8'h10, 9'd300, -1, -1, 1'b0);
        check("len300_err", err, 1);

        // Corrupted third readback word.
        for (int i = 0; i < 5; i++) wbuf[i] = 20'(i * 7 + 3);
        run_op(8'h20, 9'd5, -1, -1, 1'b1);
        check("corrupt_err", err, 1);
        check("corrupt_wsum", wsum, 28'd85);

        // Stall mid-load plus an ignored start.
        for (int i = 0; i < 6; i++) wbuf[i] = 20'((i + 1) * 10);
        run_op(8'h40, 9'd6, 3, 4, 1'b0);
        check("stall_err", err, 0);
        check("stall_wsum", wsum, 28'd210);

        // Reset asserted during a write cycle.
        model_on = 1'b0;
        @(negedge clk);
        start = 1'b1;
        base_addr = 8'h10;
        len = 9'd8;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data = 20'(i + 100);
            waited = 0;
            while (!bus.in_ready && waited < 50) begin
                @(negedge clk);
                waited++;
            end
            @(negedge clk);
        end
        check("pre_reset_wen", bus.WEN, 0);
        bus.in_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("async_rst_cen", bus.CEN, 1);
        check("async_rst_wen", bus.WEN, 1);
        check("async_rst_busy", busy, 0);
        check("async_rst_wsum", wsum, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_on = 1'b1;
        for (int i = 0; i < 3; i++) wbuf[i] = 20'(i + 7);
        run_op(8'h30, 9'd3, -1, -1, 1'b0);
        check("after_rst_err", err, 0);
        check("after_rst_wsum", wsum, 28'd24);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
